// File: rtl/pulse_window_counter_v3_if.sv
// rtl/pulse_window_counter_v3_if.sv - pulse input, window control and result record bundle
interface pulse_window_counter_v3_if #(
    parameter int LANES = 16,
    parameter int CNT_W = 24,
    parameter int WIN_W = 24,
    parameter int IDX_W = 8
);
    localparam int PW = $clog2(LANES + 1);

    logic             valid_in;
    logic [PW-1:0]    pulse_in;
    logic             count_enable;
    logic [1:0]       mode;
    logic [WIN_W-1:0] window_cycles;
    logic             gate_in;
    logic             window_active;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_count;
    logic [WIN_W-1:0] res_cycles;
    logic [PW-1:0]    res_peak;
    logic             res_overflow;
    logic [IDX_W-1:0] res_index;
    logic [7:0]       dropped_count;

    modport master (
        output valid_in, pulse_in, count_enable, mode, window_cycles, gate_in, res_ready,
        input  window_active, res_valid, res_count, res_cycles, res_peak, res_overflow,
               res_index, dropped_count
    );

    modport slave (
        input  valid_in, pulse_in, count_enable, mode, window_cycles, gate_in, res_ready,
        output window_active, res_valid, res_count, res_cycles, res_peak, res_overflow,
               res_index, dropped_count
    );
endinterface

// File: rtl/pulse_window_counter_v3.sv
// rtl/pulse_window_counter_v3.sv - windowed pulse accumulator with buffered result records
module pulse_window_counter_v3 #(
    parameter int LANES     = 16,
    parameter int CNT_W     = 24,
    parameter int WIN_W     = 24,
    parameter int IDX_W     = 8,
    parameter int RES_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    pulse_window_counter_v3_if.slave bus
);
    localparam int PW    = $clog2(LANES + 1);
    localparam int AW    = $clog2(RES_DEPTH);
    localparam int SUM_W = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam int REC_W = CNT_W + WIN_W + PW + 1 + IDX_W;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] acc;
    logic [WIN_W-1:0] cyc, len_q;
    logic [PW-1:0]    peak;
    logic             ovf;
    logic [1:0]       mode_q;
    logic             need_low;
    logic [IDX_W-1:0] idx;
    logic [7:0]       dropped;

    logic [REC_W-1:0] mem [RES_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fill;

    logic             ce, in_run, arm_start, counting, gate_close, take, sat;
    logic             timeout, close, continuing, load_run, timeout_gated;
    logic [WIN_W-1:0] eff_len, cur_len, cur_cyc, cyc_inc;
    logic [CNT_W-1:0] base_acc, acc_nx;
    logic [PW-1:0]    base_peak, peak_nx;
    logic             base_ovf, ovf_nx;
    logic [SUM_W-1:0] sum_w;
    logic [REC_W-1:0] rec;
    logic             pop, full, wr_en, drop;
    logic [CNT_W-1:0] h_count;
    logic [WIN_W-1:0] h_cycles;
    logic [PW-1:0]    h_peak;
    logic             h_ovf;
    logic [IDX_W-1:0] h_idx;

    // Window datapath: the cycle that opens a gated window (still in ARM) counts as cycle 0,
    // so the same accumulate/close arithmetic serves both the RUN cycles and that opening cycle.
    always_comb begin
        ce         = bus.count_enable;
        in_run     = (state == RUN);
        eff_len    = (bus.window_cycles == '0) ? WIN_W'(1) : bus.window_cycles;
        arm_start  = (state == ARM) && ce && bus.gate_in && !need_low;
        counting   = in_run || arm_start;
        cur_len    = in_run ? len_q : eff_len;
        cur_cyc    = in_run ? cyc : '0;
        cyc_inc    = cur_cyc + 1'b1;
        base_acc   = in_run ? acc : '0;
        base_peak  = in_run ? peak : '0;
        base_ovf   = in_run ? ovf : 1'b0;
        gate_close = in_run && (mode_q == 2'd2) && !bus.gate_in;
        take       = bus.valid_in && !gate_close;
        sum_w      = SUM_W'(base_acc) + SUM_W'(bus.pulse_in);
        sat        = sum_w > SUM_W'({CNT_W{1'b1}});
        acc_nx     = take ? (sat ? {CNT_W{1'b1}} : sum_w[CNT_W-1:0]) : base_acc;
        ovf_nx     = base_ovf | (take & sat);
        peak_nx    = (take && (bus.pulse_in > base_peak)) ? bus.pulse_in : base_peak;
        timeout    = (cur_cyc == cur_len - 1'b1);
        close      = counting && ce && (gate_close || timeout);
        rec        = gate_close ? {base_acc, cur_cyc, base_peak, base_ovf, idx}
                                : {acc_nx, cyc_inc, peak_nx, ovf_nx, idx};
        continuing = in_run && close && ((mode_q == 2'd0) || (mode_q == 2'd3)) && (bus.mode != 2'd2);
        load_run   = ((state == IDLE) && ce && (bus.mode != 2'd2)) || continuing;
        timeout_gated = close && !gate_close && (arm_start || (in_run && (mode_q == 2'd2)));
    end

    // Next-state logic; dropping count_enable always wins and abandons the open window.
    always_comb begin
        state_nx = state;
        if (!ce) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = (bus.mode == 2'd2) ? ARM : RUN;
                ARM:  if (arm_start && !close) state_nx = RUN;
                RUN: begin
                    if (close) begin
                        if (mode_q == 2'd1)        state_nx = DONE;
                        else if (mode_q == 2'd2)   state_nx = ARM;
                        else if (bus.mode == 2'd2) state_nx = ARM;
                        else                       state_nx = RUN;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Window registers, index and gate re-arm flag (a timed-out gate must fall before reopening).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0; cyc <= '0; len_q <= '0; peak <= '0; ovf <= 1'b0;
            mode_q <= 2'd0; need_low <= 1'b0; idx <= '0;
        end else begin
            if (load_run) begin
                mode_q <= bus.mode; len_q <= eff_len;
                acc <= '0; cyc <= '0; peak <= '0; ovf <= 1'b0;
            end else if (arm_start && !close) begin
                mode_q <= 2'd2; len_q <= eff_len;
                acc <= acc_nx; cyc <= WIN_W'(1); peak <= peak_nx; ovf <= ovf_nx;
            end else if (in_run && !close) begin
                acc <= acc_nx; cyc <= cyc_inc; peak <= peak_nx; ovf <= ovf_nx;
            end
            if (close) idx <= idx + 1'b1;
            if (timeout_gated)            need_low <= 1'b1;
            else if (!bus.gate_in || !ce) need_low <= 1'b0;
        end
    end

    assign pop   = bus.res_valid && bus.res_ready;
    assign full  = (fill == (AW + 1)'(RES_DEPTH));
    assign wr_en = close && (!full || pop);
    assign drop  = close && full && !pop;

    // Result storage; contents are only observed through the occupancy-qualified head.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rec;
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0; rd_ptr <= '0; fill <= '0; dropped <= 8'd0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (drop && (dropped != 8'hFF)) dropped <= dropped + 1'b1;
        end
    end

    assign {h_count, h_cycles, h_peak, h_ovf, h_idx} = mem[rd_ptr];

    assign bus.res_valid     = (fill != '0);
    assign bus.res_count     = bus.res_valid ? h_count  : '0;
    assign bus.res_cycles    = bus.res_valid ? h_cycles : '0;
    assign bus.res_peak      = bus.res_valid ? h_peak   : '0;
    assign bus.res_overflow  = bus.res_valid && h_ovf;
    assign bus.res_index     = bus.res_valid ? h_idx    : '0;
    assign bus.window_active = (state == RUN);
    assign bus.dropped_count = dropped;
endmodule

// File: tb/tb_pulse_window_counter_v3.sv
// tb/tb_pulse_window_counter_v3.sv - self-checking bench for pulse_window_counter_v3
module tb_pulse_window_counter_v3;
    localparam int DEPTH = 4;
    localparam int MAXC  = 24'hFFFFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pulse_window_counter_v3_if #(.LANES(16), .CNT_W(24), .WIN_W(24), .IDX_W(8)) b();
    pulse_window_counter_v3_if #(.LANES(16), .CNT_W(4),  .WIN_W(24), .IDX_W(8)) bs();

    assign bs.valid_in      = b.valid_in;
    assign bs.pulse_in      = b.pulse_in;
    assign bs.count_enable  = b.count_enable;
    assign bs.mode          = b.mode;
    assign bs.window_cycles = b.window_cycles;
    assign bs.gate_in       = b.gate_in;
    assign bs.res_ready     = b.res_ready;

    pulse_window_counter_v3 #(.LANES(16), .CNT_W(24), .WIN_W(24), .IDX_W(8), .RES_DEPTH(DEPTH))
        dut (.clk(clk), .rst(rst), .bus(b));
    pulse_window_counter_v3 #(.LANES(16), .CNT_W(4), .WIN_W(24), .IDX_W(8), .RES_DEPTH(DEPTH))
        dut_s (.clk(clk), .rst(rst), .bus(bs));

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit ce; bit vin; int pulse;
        bit act; bit vld; int cnt; int cyc; int pk; int ix;
    } vec_t;
    vec_t tv[10];

    typedef struct { int cnt; int cyc; int pk; int ovf; int ix; } rec_t;
    rec_t q[$];
    int m_st, m_mode, m_len, m_pos, m_acc, m_pk, m_ovf, m_idx, m_drop;

    task automatic chk(input string nm, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        b.valid_in = 0; b.pulse_in = 0; b.count_enable = 0; b.mode = 0;
        b.window_cycles = 0; b.gate_in = 0; b.res_ready = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (b.res_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic start_window();
        m_mode = int'(b.mode);
        m_len  = (b.window_cycles == 0) ? 1 : int'(b.window_cycles);
        m_pos = 0; m_acc = 0; m_pk = 0; m_ovf = 0;
    endtask

    // Reference: one clock of the window/FIFO rules for modes 0, 1 and 3.
    task automatic model_step();
        bit pop, push, full;
        rec_t r;
        pop  = (q.size() > 0) && b.res_ready;
        push = 0;
        r = '{0, 0, 0, 0, 0};
        if (!b.count_enable) begin
            m_st = 0;
        end else if (m_st == 0) begin
            m_st = 1;
            start_window();
        end else if (m_st == 1) begin
            if (b.valid_in) begin
                m_acc += int'(b.pulse_in);
                if (m_acc > MAXC) begin m_acc = MAXC; m_ovf = 1; end
                if (int'(b.pulse_in) > m_pk) m_pk = int'(b.pulse_in);
            end
            if (m_pos == m_len - 1) begin
                r = '{m_acc, m_len, m_pk, m_ovf, m_idx};
                push = 1;
                m_idx = (m_idx + 1) % 256;
                if (m_mode == 1) m_st = 2;
                else start_window();
            end else begin
                m_pos++;
            end
        end
        full = (q.size() == DEPTH);
        if (pop) void'(q.pop_front());
        if (push) begin
            if (!full || pop) q.push_back(r);
            else if (m_drop < 255) m_drop++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int seen, got_cnt, got_cyc;

        // Reset state
        do_reset();
        chk("rst_valid", b.res_valid, 0);
        chk("rst_active", b.window_active, 0);
        chk("rst_dropped", b.dropped_count, 0);
        chk("rst_count", b.res_count, 0);
        chk("rst_index", b.res_index, 0);

        // Continuous mode, table driven
        tv[0] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        tv[1] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        tv[2] = '{1, 1, 2, 1, 0, 0, 0, 0, 0};
        tv[3] = '{1, 1, 3, 1, 0, 0, 0, 0, 0};
        tv[4] = '{1, 1, 0, 1, 1, 6, 4, 3, 0};
        tv[5] = '{1, 1, 5, 1, 0, 0, 0, 0, 0};
        tv[6] = '{1, 1, 5, 1, 0, 0, 0, 0, 0};
        tv[7] = '{1, 1, 5, 1, 0, 0, 0, 0, 0};
        tv[8] = '{1, 1, 5, 1, 1, 20, 4, 5, 1};
        tv[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        b.mode = 0; b.window_cycles = 4; b.res_ready = 1;
        for (int i = 0; i < 10; i++) begin
            b.count_enable = tv[i].ce;
            b.valid_in = tv[i].vin;
            b.pulse_in = 5'(tv[i].pulse);
            tick();
            chk($sformatf("m0_active[%0d]", i), b.window_active, tv[i].act);
            chk($sformatf("m0_valid[%0d]", i), b.res_valid, tv[i].vld);
            if (tv[i].vld) begin
                chk($sformatf("m0_count[%0d]", i), b.res_count, tv[i].cnt);
                chk($sformatf("m0_cycles[%0d]", i), b.res_cycles, tv[i].cyc);
                chk($sformatf("m0_peak[%0d]", i), b.res_peak, tv[i].pk);
                chk($sformatf("m0_index[%0d]", i), b.res_index, tv[i].ix);
            end
        end

        // Single-shot
        do_reset();
        b.mode = 1; b.window_cycles = 3; b.count_enable = 1; b.valid_in = 1; b.pulse_in = 2; b.res_ready = 1;
        tick();
        chk("m1_active", b.window_active, 1);
        tick();
        tick();
        chk("m1_early", b.res_valid, 0);
        tick();
        chk("m1_valid", b.res_valid, 1);
        chk("m1_count", b.res_count, 6);
        chk("m1_cycles", b.res_cycles, 3);
        chk("m1_inactive", b.window_active, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b.res_valid) seen++;
        end
        chk("m1_norestart", seen, 0);
        b.count_enable = 0;
        tick();
        b.count_enable = 1;
        wait_valid(10, ok);
        chk("m1_rearm_ok", ok, 1);
        chk("m1_rearm_count", b.res_count, 6);
        chk("m1_rearm_index", b.res_index, 1);

        // Gated
        do_reset();
        b.mode = 2; b.window_cycles = 100; b.count_enable = 1; b.valid_in = 1; b.pulse_in = 1; b.res_ready = 1;
        tick();
        chk("m2_arm_inactive", b.window_active, 0);
        b.gate_in = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("m2_active", b.window_active, 1);
        b.gate_in = 0;
        tick();
        chk("m2_valid", b.res_valid, 1);
        chk("m2_count", b.res_count, 5);
        chk("m2_cycles", b.res_cycles, 5);
        b.window_cycles = 3;
        b.gate_in = 1;
        seen = 0; got_cnt = -1; got_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b.res_valid) begin
                if (seen == 0) begin got_cnt = int'(b.res_count); got_cyc = int'(b.res_cycles); end
                seen++;
            end
        end
        chk("m2_to_records", seen, 1);
        chk("m2_to_count", got_cnt, 3);
        chk("m2_to_cycles", got_cyc, 3);
        chk("m2_to_inactive", b.window_active, 0);
        b.gate_in = 0;
        tick();
        b.gate_in = 1;
        wait_valid(10, ok);
        chk("m2_rerise_ok", ok, 1);
        chk("m2_rerise_index", b.res_index, 2);

        // FIFO full and drops
        do_reset();
        b.mode = 0; b.window_cycles = 1; b.count_enable = 1; b.valid_in = 1; b.pulse_in = 1; b.res_ready = 0;
        for (int i = 0; i < 7; i++) tick();
        b.count_enable = 0;
        tick();
        chk("ff_dropped", b.dropped_count, 2);
        chk("ff_valid", b.res_valid, 1);
        chk("ff_count", b.res_count, 1);
        chk("ff_cycles", b.res_cycles, 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ff_pop_index[%0d]", k), b.res_index, k);
            b.res_ready = 1;
            tick();
            b.res_ready = 0;
        end
        chk("ff_empty", b.res_valid, 0);
        b.count_enable = 1;
        wait_valid(10, ok);
        chk("ff_next_ok", ok, 1);
        chk("ff_next_index", b.res_index, 6);

        // Saturation on the narrow instance
        do_reset();
        b.mode = 0; b.window_cycles = 8; b.count_enable = 1; b.valid_in = 1; b.pulse_in = 16; b.res_ready = 1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bs.res_valid) begin ok = 1; break; end
        end
        chk("sat_ok", ok, 1);
        chk("sat_count", bs.res_count, 15);
        chk("sat_ovf", bs.res_overflow, 1);
        chk("sat_peak", bs.res_peak, 16);
        chk("sat_cycles", bs.res_cycles, 8);
        chk("wide_count", b.res_count, 128);
        chk("wide_ovf", b.res_overflow, 0);

        // Abort and asynchronous reset
        do_reset();
        b.mode = 0; b.window_cycles = 4; b.count_enable = 1; b.valid_in = 1; b.pulse_in = 1; b.res_ready = 1;
        tick();
        tick();
        tick();
        b.count_enable = 0;
        tick();
        chk("ab_inactive", b.window_active, 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b.res_valid) seen++;
        end
        chk("ab_norecord", seen, 0);
        b.count_enable = 1;
        wait_valid(12, ok);
        b.res_ready = 0;
        chk("ab_next_ok", ok, 1);
        chk("ab_next_index", b.res_index, 0);
        chk("ab_next_count", b.res_count, 4);
        tick();
        tick();
        chk("ar_held", b.res_valid, 1);
        #2;
        rst = 1;
        #1;
        chk("ar_valid", b.res_valid, 0);
        chk("ar_active", b.window_active, 0);
        chk("ar_count", b.res_count, 0);
        chk("ar_dropped", b.dropped_count, 0);
        tick();
        rst = 0;

        // Randomized against the reference model
        do_reset();
        q.delete();
        m_st = 0; m_idx = 0; m_drop = 0;
        m_mode = 0; m_len = 1; m_pos = 0; m_acc = 0; m_pk = 0; m_ovf = 0;
        for (int seg = 0; seg < 40; seg++) begin
            int on_len, off_len, r;
            on_len  = $urandom_range(8, 30);
            off_len = $urandom_range(1, 2);
            for (int c = 0; c < on_len + off_len; c++) begin
                r = $urandom_range(0, 2);
                b.mode = (r == 2) ? 2'd3 : 2'(r);
                b.window_cycles = 24'($urandom_range(0, 5));
                b.count_enable = (c < on_len);
                b.valid_in = ($urandom_range(0, 3) != 0);
                b.pulse_in = 5'($urandom_range(0, 16));
                b.res_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                model_step();
                #1;
                chk("rnd_valid", b.res_valid, q.size() > 0);
                chk("rnd_active", b.window_active, m_st == 1);
                chk("rnd_dropped", b.dropped_count, m_drop);
                if (q.size() > 0) begin
                    chk("rnd_count", b.res_count, q[0].cnt);
                    chk("rnd_cycles", b.res_cycles, q[0].cyc);
                    chk("rnd_peak", b.res_peak, q[0].pk);
                    chk("rnd_ovf", b.res_overflow, q[0].ovf);
                    chk("rnd_index", b.res_index, q[0].ix);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pulse_window_counter_v3.md
Name: pulse_window_counter_v3

Overview:
Windowed pulse accumulator for the wavelet pulse-counting chain. It consumes the per-cycle pulse count from the zero-point analysis stage (0..LANES pulses per clock) and closes measurement windows in one of three modes: continuous, single-shot or externally gated. Each closed window produces a result record (count, cycle length, peak per-cycle rate, overflow flag, index). Records are buffered in a small FIFO with a valid/ready handshake, so downstream readout may stall without losing results until the buffer fills.

Parameters:
LANES, 16, max pulses per cycle; pulse_in width PW = clog2(LANES+1)
CNT_W, 24, accumulator/result count width
WIN_W, 24, window length width
IDX_W, 8, window index width
RES_DEPTH, 4, result FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid_in  in  1  pulse_in qualifier
pulse_in  in  PW  pulses detected this cycle
count_enable  in  1  level; low aborts/idles the block
mode  in  2  0=continuous, 1=single-shot, 2=gated, 3=continuous
window_cycles  in  WIN_W  window length (gated: timeout)
gate_in  in  1  window gate (mode 2 only)
window_active  out  1  high in RUN
res_valid  out  1  result record available
res_ready  in  1  downstream accepts record
res_count  out  CNT_W  pulses in window
res_cycles  out  WIN_W  clock cycles in window
res_peak  out  PW  max single-cycle pulse_in in window
res_overflow  out  1  accumulator saturated
res_index  out  IDX_W  window sequence number
dropped_count  out  8  results lost to full FIFO, saturating

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; window index 0.
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE -> RUN on count_enable=1 (modes 0/1/3). IDLE -> ARM on count_enable=1 (mode 2).
- ARM -> RUN on the first cycle gate_in=1. That cycle is window cycle 0.
- On entering RUN: latch mode and window_cycles. A value of 0 is treated as 1. Clear acc, cycle counter, peak and ovf.
- RUN, every cycle: cyc += 1. If valid_in: acc += pulse_in, saturating at 2^CNT_W-1 (sets ovf), and peak = max(peak, pulse_in).
- Close condition, modes 0/1/3: cycle counter == latched length-1. The closing cycle's pulse_in is included.
- Close condition, mode 2: gate_in=0 (that cycle is excluded, not counted), or timeout at latched length-1 (included).
- On close: push {acc_final, cycles, peak, ovf, index} into the FIFO, then index += 1 (wraps).
- After close, mode 0/3: the next cycle starts a new window with no gap.
- After close, mode 1: go to DONE.
- After close, mode 2: go to ARM. A gate still high after a timeout does not restart the window until gate_in goes low and then high again.
- DONE -> IDLE only when count_enable=0.
- count_enable=0 in any state: go to IDLE next cycle. A partial window is discarded with no push and no index increment. FIFO contents and dropped_count are kept.
- Mode changes mid-window are ignored until the next window start.
- FIFO: show-ahead. The head record is driven on res_*; res_valid = not empty.
- Pop on res_valid & res_ready.
- Push at the closing cycle. The record becomes visible at close+1 when the FIFO was empty.
- Push and pop in the same cycle are both honoured, even when the FIFO is full.
- Push while full with no pop: the record is dropped, dropped_count += 1 (saturates at 255), and the index still increments.
- res_* fields are stable while res_valid=1 and res_ready=0.
- window_active = (state == RUN).

Test Plan:
- Mode 0, window_cycles=4, valid_in=1, pulse_in=1,2,3,0,5,5,5,5; res_ready=1 -> two records: (count 6, cycles 4, peak 3, index 0) then (count 20, cycles 4, peak 5, index 1), each res_valid at close+1.
- Mode 1, window_cycles=3, pulse_in=2 constant -> one record (count 6); window_active falls; no further records until count_enable toggles 0 then 1.
- Mode 2, gate high 5 cycles with pulse_in=1, window_cycles=100 -> record (count 5, cycles 5). With window_cycles=3 and the gate held 10 cycles -> a single record (count 3, cycles 3) and no restart until the gate re-rises.
- RES_DEPTH=4, res_ready=0, mode 0, window_cycles=1, 6 windows -> 4 records held; dropped_count=2; popped indices 0,1,2,3; the next accepted record has index 6.
- CNT_W=4, window_cycles=8, pulse_in=LANES=16 -> res_count=15, res_overflow=1.
- count_enable dropped at window cycle 2 of 4 -> no record, index unchanged; rst asserted mid-window -> all outputs 0 immediately.
